// File: rtl/rom_scanner_if.sv
// Socket-side bundle for rom_scanner: key/mode controls in, chip pins and status out.
interface rom_scanner_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     enable;
    logic                     mode;
    logic                     start;
    logic                     increment_address;
    logic                     decrement_address;
    logic [DATA_WIDTH-1:0]    data_line_in;
    logic [3:0]               operation;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    data_line;
    logic                     data_valid;
    logic                     busy;
    logic                     scan_done;

    modport master (
        output enable, mode, start, increment_address, decrement_address, data_line_in,
        input  operation, address_line, data_line, data_valid, busy, scan_done
    );

    modport slave (
        input  enable, mode, start, increment_address, decrement_address, data_line_in,
        output operation, address_line, data_line, data_valid, busy, scan_done
    );
endinterface

// File: rtl/rom_scanner.sv
// ROM reader for 556PT4/PT5 sockets: manual key stepping or full auto scan,
// with an address-settle delay before each data sample.
module rom_scanner #(
    parameter int       DATA_WIDTH     = 8,
    parameter int       ADDRESS_WIDTH  = 9,
    parameter int       MAX_ADDRESS    = 2**ADDRESS_WIDTH - 1,
    parameter int       SETTLE_CYCLES  = 4,
    parameter bit [3:0] READ_OPERATION = 4'b1100
) (
    input  logic           clk,
    input  logic           reset,
    rom_scanner_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, ADVANCE, DONE} state_t;

    localparam int                       CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]         SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = ADDRESS_WIDTH'(MAX_ADDRESS);

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] address, address_next;
    logic [CNT_W-1:0]         settle_cnt, settle_cnt_next;
    logic                     auto_scan, auto_scan_next;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [3:0]               operation_q;
    logic                     valid_q, valid_next;
    logic                     done_q, done_next;
    logic                     capture;
    logic                     inc_q, dec_q, start_q;
    logic                     inc_evt, dec_evt, start_evt;

    // Key levels are compared with last clock's sample so a held key steps once.
    assign inc_evt   = bus.increment_address & ~inc_q;
    assign dec_evt   = bus.decrement_address & ~dec_q;
    assign start_evt = bus.start & ~start_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_next      = state;
        address_next    = address;
        settle_cnt_next = settle_cnt;
        auto_scan_next  = auto_scan;
        capture         = 1'b0;
        valid_next      = 1'b0;
        done_next       = 1'b0;

        if (!bus.enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mode) begin
                        if (start_evt) begin
                            address_next    = '0;
                            auto_scan_next  = 1'b1;
                            settle_cnt_next = SETTLE_LOAD;
                            state_next      = SETTLE;
                        end
                    end else if (inc_evt && !dec_evt) begin
                        address_next    = (address == LAST_ADDR) ? '0 : address + ADDRESS_WIDTH'(1);
                        auto_scan_next  = 1'b0;
                        settle_cnt_next = SETTLE_LOAD;
                        state_next      = SETTLE;
                    end else if (dec_evt && !inc_evt) begin
                        address_next    = (address == '0) ? LAST_ADDR : address - ADDRESS_WIDTH'(1);
                        auto_scan_next  = 1'b0;
                        settle_cnt_next = SETTLE_LOAD;
                        state_next      = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_W'(1)) state_next = SAMPLE;
                    else settle_cnt_next = settle_cnt - CNT_W'(1);
                end
                SAMPLE: begin
                    capture    = 1'b1;
                    valid_next = 1'b1;
                    if (!auto_scan)              state_next = IDLE;
                    else if (address == LAST_ADDR) state_next = DONE;
                    else                         state_next = ADVANCE;
                end
                ADVANCE: begin
                    address_next    = address + ADDRESS_WIDTH'(1);
                    settle_cnt_next = SETTLE_LOAD;
                    state_next      = SETTLE;
                end
                DONE: begin
                    done_next    = 1'b1;
                    address_next = '0;
                    state_next   = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            address     <= '0;
            settle_cnt  <= '0;
            auto_scan   <= 1'b0;
            data_q      <= '0;
            operation_q <= 4'b0000;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state       <= state_next;
            address     <= address_next;
            settle_cnt  <= settle_cnt_next;
            auto_scan   <= auto_scan_next;
            valid_q     <= valid_next;
            done_q      <= done_next;
            operation_q <= bus.enable ? READ_OPERATION : 4'b0000;
            inc_q       <= bus.increment_address;
            dec_q       <= bus.decrement_address;
            start_q     <= bus.start;
            if (capture) data_q <= bus.data_line_in;
        end
    end

    assign bus.operation    = operation_q;
    assign bus.address_line = address;
    assign bus.data_line    = data_q;
    assign bus.data_valid   = valid_q;
    assign bus.scan_done    = done_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: doc/rom_scanner.md
Name: rom_scanner

Overview:
- Parametrised successor to the single-step ROM reader for 556PT5 (3604, 8x512) and 556PT4 (3601, 4x256) chips.
- Adds the following over the single-step reader:
  - configurable address width and maximum address;
  - an address-settle delay before each sample;
  - a one-cycle data_valid strobe;
  - an auto-scan mode that walks the whole chip and flags completion.
- Sits between the top-level key/clock selection logic and the chip socket pins.

Parameters:
- DATA_WIDTH, 8, chip data width (8 for 3604, 4 for 3601).
- ADDRESS_WIDTH, 9, chip address width (9 for 3604, 8 for 3601).
- MAX_ADDRESS, 2**ADDRESS_WIDTH-1, last valid address; wrap point.
- SETTLE_CYCLES, 4, clocks between an address change and the data sample; must be at least 1.
- READ_OPERATION, 4'b1100, operation (V1..V4) code driven while enabled.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  chip access enable; when low, chip deselected and FSM idle.
- mode  in  1  0 = manual step, 1 = auto scan; sampled only in IDLE.
- start  in  1  auto-scan start; rising edge, honoured only in IDLE with mode=1.
- increment_address  in  1  manual step up (key level, synchronous to clk).
- decrement_address  in  1  manual step down (key level, synchronous to clk).
- data_line_in  in  DATA_WIDTH  data from chip.
- operation  out  4  chip operation code: V1=bit0 .. V4=bit3.
- address_line  out  ADDRESS_WIDTH  chip address.
- data_line  out  DATA_WIDTH  last sampled data.
- data_valid  out  1  one-clock strobe; data_line holds the sample for the current address_line.
- busy  out  1  high in any state other than IDLE.
- scan_done  out  1  one-clock strobe after the MAX_ADDRESS sample of an auto scan.

Behaviour:
- Reset (async, high) forces:
  - address_line = 0, data_line = 0, operation = 4'b0000;
  - data_valid = busy = scan_done = 0;
  - state = IDLE, edge-detect registers cleared.
- operation:
  - READ_OPERATION whenever enable = 1 and not in reset;
  - 4'b0000 otherwise (registered, updates one clock after enable changes).
- Edge detection:
  - increment_address, decrement_address and start are registered every clock.
  - An event is current = 1 while the previous sample = 0.
  - A held key produces exactly one event.
- FSM states:
  - IDLE, SETTLE, SAMPLE, ADVANCE, DONE.
- IDLE:
  - mode = 0, increment event, no decrement event: address <= (address == MAX_ADDRESS) ? 0 : address + 1; go to SETTLE.
  - mode = 0, decrement event, no increment event: address <= (address == 0) ? MAX_ADDRESS : address - 1; go to SETTLE.
  - Both events on the same clock: ignored, stay in IDLE.
  - mode = 1 and start event: address <= 0; go to SETTLE.
  - Key/start events arriving outside IDLE are discarded, not queued.
- SETTLE:
  - Counter loaded with SETTLE_CYCLES on entry.
  - Decrements each clock; goes to SAMPLE when it reaches 1.
  - Stays exactly SETTLE_CYCLES clocks.
- SAMPLE:
  - data_line <= data_line_in; data_valid = 1 for this clock only.
  - Manual mode: next state is IDLE.
  - Auto mode, address < MAX_ADDRESS: next state is ADVANCE.
  - Auto mode, address == MAX_ADDRESS: next state is DONE.
- ADVANCE:
  - address <= address + 1; go to SETTLE.
- DONE:
  - scan_done = 1 for one clock; address <= 0; go to IDLE.
- Latency:
  - data_valid is high on the clock SETTLE_CYCLES+1 edges after the edge that updated address_line.
  - Auto-scan period is SETTLE_CYCLES+2 clocks per address.
  - Full scan: (MAX_ADDRESS+1)*(SETTLE_CYCLES+2) clocks from the start edge to the scan_done clock.
- enable = 0 mid-operation:
  - FSM returns to IDLE on the next clock with no data_valid or scan_done.
  - address_line and data_line are held.
- mode changes mid-scan are ignored until IDLE.
- All counters are sized to MAX_ADDRESS and SETTLE_CYCLES, with no overflow at any parameter setting.

Test Plan:
- Reset, enable = 1, mode = 0, SETTLE_CYCLES = 4, increment pulse -> address_line = 1 one clock later; data_valid on the 5th following edge with data_line = data_line_in (e.g. 8'hA5).
- At address 0, decrement pulse -> address_line = 511 (3604 params); at 511, increment pulse -> 0; increment held high 20 clocks -> exactly one step.
- Increment and decrement rising together -> no address change, busy stays 0.
- mode = 1, ADDRESS_WIDTH = 8, DATA_WIDTH = 4, SETTLE_CYCLES = 2, start pulse, data_line_in = address[3:0] -> 256 data_valid strobes with matching data; scan_done 1024 clocks after start; address_line = 0 afterwards.
- Mid auto scan at address 37, drop enable -> next clock IDLE, busy = 0, operation = 0000, address_line = 37, no scan_done.
- Assert reset asynchronously mid-SETTLE (between edges) -> all outputs immediately at reset values.
